// File: rtl/ws2812_encoder_if.sv
// Pixel stream handshake into the WS2812 encoder.
// A pixel transfers on a cycle where pix_valid and pix_ready are both high.
interface ws2812_encoder_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/ws2812_encoder.sv
// WS2812 serial encoder: shifts 24-bit GRB pixels out MSB first as timed high/low pulses,
// then holds the line low for a latch period at the end of each frame.
module ws2812_encoder #(
  parameter int unsigned T0H_CYC   = 20,
  parameter int unsigned T1H_CYC   = 40,
  parameter int unsigned BIT_CYC   = 63,
  parameter int unsigned LATCH_CYC = 2750
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  ws2812_encoder_if.slave pix_if,
  output logic            do_o,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            underrun_o
);

  localparam logic [7:0]  T0HEnd   = 8'(T0H_CYC - 1);
  localparam logic [7:0]  T1HEnd   = 8'(T1H_CYC - 1);
  localparam logic [7:0]  Low0End  = 8'(BIT_CYC - T0H_CYC - 1);
  localparam logic [7:0]  Low1End  = 8'(BIT_CYC - T1H_CYC - 1);
  localparam logic [15:0] LatchEnd = 16'(LATCH_CYC - 1);

  typedef enum logic [2:0] {StIdle, StHigh, StLow, StGap, StLatch} state_e;

  state_e      state_q, state_d;
  logic [23:0] sr_q, sr_d;
  logic [4:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] lat_cnt_q, lat_cnt_d;
  logic        do_q, do_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;
  logic        high_end, low_end, ready, xfer;

  // sr_q[23] is always the bit currently on the wire
  assign high_end = (bit_cnt_q == (sr_q[23] ? T1HEnd : T0HEnd));
  assign low_end  = (bit_cnt_q == (sr_q[23] ? Low1End : Low0End));

  // Accepting in the final LOW cycle of bit 0 lets a stream continue without a bubble
  assign ready = (state_q == StIdle) || (state_q == StGap) ||
                 ((state_q == StLow) && low_end && (idx_q == 5'd0) && !last_q);
  assign xfer  = pix_if.pix_valid && ready;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    idx_d        = idx_q;
    last_d       = last_q;
    bit_cnt_d    = bit_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;

    // A transfer wins over every other transition, including GAP timeout
    if (xfer) begin
      sr_d      = pix_if.pix_data;
      last_d    = pix_if.pix_last;
      idx_d     = 5'd23;
      bit_cnt_d = 8'd0;
      lat_cnt_d = 16'd0;
      state_d   = StHigh;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHigh: begin
          if (high_end) begin
            bit_cnt_d = 8'd0;
            state_d   = StLow;
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
        StLow: begin
          if (low_end) begin
            bit_cnt_d = 8'd0;
            lat_cnt_d = 16'd0;
            if (idx_q != 5'd0) begin
              sr_d    = {sr_q[22:0], 1'b0};
              idx_d   = idx_q - 5'd1;
              state_d = StHigh;
            end else if (last_q) begin
              state_d = StLatch;
            end else begin
              state_d = StGap;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
        StGap: begin
          if (lat_cnt_q == LatchEnd) begin
            underrun_d = 1'b1;
            lat_cnt_d  = 16'd0;
            state_d    = StLatch;
          end else begin
            lat_cnt_d = lat_cnt_q + 16'd1;
          end
        end
        StLatch: begin
          if (lat_cnt_q == LatchEnd) begin
            frame_done_d = 1'b1;
            lat_cnt_d    = 16'd0;
            state_d      = StIdle;
          end else begin
            lat_cnt_d = lat_cnt_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    do_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sr_q         <= 24'd0;
      idx_q        <= 5'd0;
      last_q       <= 1'b0;
      bit_cnt_q    <= 8'd0;
      lat_cnt_q    <= 16'd0;
      do_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      bit_cnt_q    <= bit_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      do_q         <= do_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pix_if.pix_ready = ready;
  assign do_o             = do_q;
  assign busy_o           = (state_q != StIdle);
  assign frame_done_o     = frame_done_q;
  assign underrun_o       = underrun_q;

endmodule

// File: doc/ws2812_encoder.md
WS2812_ENCODER -- requirements
Module: ws2812_encoder

Interface
REQ-001 SHALL provide parameter T0H_CYC, default 20, meaning DO high time in CLK cycles for a 0 bit (0.4 us at 50 MHz).
REQ-002 SHALL provide parameter T1H_CYC, default 40, meaning DO high time in CLK cycles for a 1 bit (0.8 us).
REQ-003 SHALL provide parameter BIT_CYC, default 63, meaning total CLK cycles per bit (1.26 us); legal range T1H_CYC < BIT_CYC <= 255.
REQ-004 SHALL provide parameter LATCH_CYC, default 2750, meaning CLK cycles DO is held low to latch a frame (55 us); legal range 1..65535.
REQ-005 CLK  input  1  system clock; all logic on its rising edge; one clock domain only.
REQ-006 RST_N  input  1  reset, synchronous, active-low.
REQ-007 PIX_DATA  input  24  pixel word, GRB order, bit 23 = G7, sent first.
REQ-008 PIX_VALID  input  1  PIX_DATA/PIX_LAST valid.
REQ-009 PIX_LAST  input  1  the accompanying pixel is the final pixel of the frame.
REQ-010 PIX_READY  output  1  encoder accepts a pixel this cycle; transfer = PIX_VALID & PIX_READY.
REQ-011 DO  output  1  WS2812 serial data line.
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 FRAME_DONE  output  1  single-cycle pulse when a latch period completes.
REQ-014 UNDERRUN  output  1  sticky flag: a frame was terminated by a pixel gap rather than PIX_LAST.

Function
REQ-015 FSM states SHALL be IDLE, HIGH, LOW, GAP, LATCH.
REQ-016 IDLE: DO=0, PIX_READY=1; on transfer, capture PIX_DATA into a 24-bit shift register, PIX_LAST into a last flag, set bit index 23, and enter HIGH next cycle.
REQ-017 HIGH: DO=1 for exactly T1H_CYC cycles if the current bit is 1, T0H_CYC cycles if 0, then enter LOW.
REQ-018 LOW: DO=0 for BIT_CYC minus the high time, so each bit occupies exactly BIT_CYC cycles measured between DO rising edges.
REQ-019 At the end of LOW with bit index > 0: shift left by one, decrement the index, and enter HIGH.
REQ-020 At the end of LOW with bit index 0: enter LATCH if the last flag is set, otherwise enter GAP.
REQ-021 PIX_READY SHALL also be 1 in the final LOW cycle of bit 0 when the last flag is clear; a transfer then loads the new pixel and enters HIGH with no extra cycle (gapless stream).
REQ-022 GAP: DO=0, PIX_READY=1, gap counter increments each cycle; on transfer, load the pixel and enter HIGH; if the counter reaches LATCH_CYC without a transfer, set UNDERRUN and enter LATCH.
REQ-023 LATCH: DO=0, PIX_READY=0; hold for LATCH_CYC cycles, then pulse FRAME_DONE for one cycle and enter IDLE.
REQ-024 A transfer in the same cycle that GAP times out SHALL take priority: the pixel is loaded and UNDERRUN is not set.
REQ-025 PIX_DATA and PIX_LAST SHALL be sampled only on a transfer; changes at other times SHALL have no effect.
REQ-026 Bit timing counter SHALL be 8 bits and latch/gap counter 16 bits; neither counter shall wrap within a state.
REQ-027 DO SHALL be driven directly from a register, glitch-free.

Reset
REQ-028 When RST_N=0 at a rising CLK edge: state=IDLE, DO=0, PIX_READY=1 on the following cycle, BUSY=0, FRAME_DONE=0, UNDERRUN=0, counters and shift register=0.
REQ-029 Reset asserted mid-bit or mid-latch SHALL abort immediately; DO SHALL be low from the next cycle; no FRAME_DONE is generated.

Verification
REQ-030 Single pixel 0x800000 with PIX_LAST=1 -> first bit DO high 40 cycles then low 23; next 23 bits high 20 / low 43; then DO low 2750 cycles; FRAME_DONE pulses once.
REQ-031 Two back-to-back pixels 0xFFFFFF, 0x000000 (second with PIX_LAST=1), PIX_VALID held high -> 48 bits with rising edges spaced exactly 63 cycles; PIX_READY high for exactly one cycle between the pixels.
REQ-032 Pixel 0x0F0F0F without PIX_LAST and PIX_VALID low afterwards -> GAP lasts 2750 cycles, then LATCH lasts 2750 cycles, then FRAME_DONE; UNDERRUN=1 and held until reset.
REQ-033 Second pixel presented on the exact cycle the GAP counter reaches 2750 -> pixel transmitted; UNDERRUN remains 0.
REQ-034 RST_N pulled low for 1 cycle during the HIGH phase of bit 10 -> DO=0 on the next cycle; IDLE with PIX_READY=1; no FRAME_DONE.
REQ-035 PIX_DATA toggled randomly while PIX_VALID=0 during transmission -> output bit stream unchanged.
